pll_reset_seq: RTL and testbench
================================

# pll_reset_seq

PLL bring-up and reset sequencer for the board clock generator. It holds the PLL in reset for a minimum pulse, then waits for a debounced lock with a timeout. Once lock is stable, it releases the per-clock-domain resets one at a time in index order. On loss of lock or a software request it tears everything down and restarts. It runs on the free-running board input clock, upstream of every PLL-derived domain.

## Interface

- RST_HOLD_CYCLES, 16: cycles `pll_rst` is held high per reset attempt (≥1).
- LOCK_STABLE_CYCLES, 1024: consecutive synchronized-lock cycles required before release (≥1).
- LOCK_TIMEOUT_CYCLES, 65536: cycles to wait for first lock before declaring timeout (≥2).
- RELEASE_GAP, 8: cycles between successive domain reset releases (≥1).
- NUM_DOMAINS, 4: number of domain resets (1..8).
- CLK  in  1: free-running board input clock, same source as the PLL input.
- RST_N  in  1: asynchronous, active-low reset. Assertion takes effect immediately; deassertion is synchronized externally.
- sw_reset_req  in  1: single-cycle request to restart the full sequence.
- pll_locked  in  1: raw PLL `LOCKED`, asynchronous to CLK.
- pll_rst  out  1: active-high PLL reset.
- domain_rst_n  out  NUM_DOMAINS: active-low domain resets, CLK-domain levels. Each consumer re-synchronizes them.
- ready  out  1: high while in RUN.
- lock_lost_cnt  out  8: saturating count of lock losses seen in RELEASE or RUN.
- timeout_err  out  1: sticky flag, set on any lock timeout, cleared only by RST_N.
- state  out  3: current FSM state encoding, for debug.

## Operation

- `pll_locked` passes through a 2-flop synchronizer to produce `lock_s`. All decisions use `lock_s` only.
- Counter width is $clog2 of the largest cycle parameter, plus 1. Counters clear on every state entry.
- RESET_PLL: `pll_rst`=1, all domain resets asserted, `ready`=0. After RST_HOLD_CYCLES cycles → WAIT_LOCK.
- WAIT_LOCK: `pll_rst`=0.
  - `lock_s`=1 → STABLE.
  - Counter reaches LOCK_TIMEOUT_CYCLES−1 with no lock → set `timeout_err`, then take the timeout action (see Configuration).
- STABLE: counts consecutive `lock_s`=1 cycles.
  - `lock_s`=0 → WAIT_LOCK. The timeout counter restarts and this is not counted as a loss.
  - Count reaches LOCK_STABLE_CYCLES → RELEASE with index 0.
- RELEASE: each time the gap counter reaches RELEASE_GAP−1, set `domain_rst_n[idx]`=1 and increment idx. After releasing index NUM_DOMAINS−1 → RUN.
- RUN: `ready`=1. Holds until an abort.
- Abort on lock loss (`lock_s`=0 in RELEASE or RUN):
  - All `domain_rst_n` go to 0 and `ready` to 0 on the next edge.
  - `lock_lost_cnt` increments, saturating at 255.
  - → RESET_PLL.
- `sw_reset_req` in any state → RESET_PLL, with domain resets asserted. The lock-loss counter does not change.
- Priority when events coincide: `sw_reset_req` > lock loss > timeout > normal progress.
- Released domains never re-assert except via a transition to RESET_PLL. Released indices are always a contiguous prefix starting at 0.

## Timing

- Reset values: `pll_rst`=1, `domain_rst_n`=0, `ready`=0, `lock_lost_cnt`=0, `timeout_err`=0, `state`=RESET_PLL.
- All outputs are registered.
- Raw lock to `lock_s`: 2 cycles.
- Lock loss to domain resets asserted: 3 cycles from the raw `pll_locked` fall.
- Domain i release occurs (i+1)·RELEASE_GAP cycles after RELEASE entry. `ready` rises on the same edge as the last release.
- `pll_rst` low pulse spacing is at least RST_HOLD_CYCLES between attempts.

## Configuration

- PLL_RETRY_EN defined: a timeout returns to RESET_PLL and retries indefinitely.
- PLL_RETRY_EN undefined: a timeout enters FAULT, with `pll_rst`=1 and all domains held. FAULT exits only on `sw_reset_req` (→ RESET_PLL) or RST_N.
- `timeout_err` behaves identically in both builds.

## Structure

- `pll_seq_pkg` holds:
  - the state enum typedef (RESET_PLL, WAIT_LOCK, STABLE, RELEASE, RUN, FAULT);
  - the 3-bit state width constant.
- One sub-module, `pll_lock_sync`: a parameter-free 2-flop synchronizer, async active-low reset, resetting to 0.

## Test plan

Bench parameters: RST_HOLD_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, RELEASE_GAP=2, NUM_DOMAINS=4.

- Nominal bring-up: release RST_N, raise `pll_locked` 10 cycles later.
  - `pll_rst` is high 4 cycles.
  - Domains 0..3 release 2 cycles apart.
  - `ready`=1 with `domain_rst_n`=4'hF.
- Lock glitch in STABLE: drop `pll_locked` for 3 cycles after 5 stable cycles → no release, `lock_lost_cnt`=0, stable count restarts.
- Loss in RUN: drop `pll_locked` → 3 cycles later `domain_rst_n`=0 and `ready`=0, `lock_lost_cnt`=1, `pll_rst` pulses again.
- Timeout: hold `pll_locked`=0 → `timeout_err`=1 after 32 WAIT_LOCK cycles.
  - With PLL_RETRY_EN, `pll_rst` re-asserts.
  - Without it, `state`=FAULT until `sw_reset_req`.
- `sw_reset_req` in RUN coincident with lock loss → RESET_PLL, `lock_lost_cnt` unchanged.
- Saturation: force 260 lock losses → `lock_lost_cnt` holds 255.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// Shared state encoding and helpers for the PLL reset sequencer.
package pll_seq_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4,
    FAULT     = 3'd5
  } state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer bringing the raw PLL lock into the board clock domain.
module pll_lock_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic synced
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta   <= 1'b0;
      synced <= 1'b0;
    end else begin
      meta   <= raw;
      synced <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_seq.sv
// PLL bring-up and per-domain reset release sequencer.
// Define PLL_RETRY_EN to retry after a lock timeout instead of parking in FAULT.
module pll_reset_seq
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_HOLD_CYCLES     = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned RELEASE_GAP         = 8,
  parameter int unsigned NUM_DOMAINS         = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sw_reset_req,
  input  logic                   pll_locked,
  output logic                   pll_rst,
  output logic [NUM_DOMAINS-1:0] domain_rst_n,
  output logic                   ready,
  output logic [7:0]             lock_lost_cnt,
  output logic                   timeout_err,
  output logic [STATE_W-1:0]     state
);

  localparam int unsigned MAX_CYC = max_u(max_u(RST_HOLD_CYCLES, LOCK_STABLE_CYCLES),
                                          max_u(LOCK_TIMEOUT_CYCLES, RELEASE_GAP));
  localparam int unsigned CNT_W = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(RELEASE_GAP - 1);

  state_e                   state_q;
  logic [CNT_W-1:0]         cnt;
  logic                     lock_s;
  logic [NUM_DOMAINS-1:0]   release_mask_c;

  pll_lock_sync u_lock_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw    (pll_locked),
    .synced (lock_s)
  );

  // Released domains always form a contiguous prefix, so the next release shifts in a one.
  assign release_mask_c = (domain_rst_n << 1) | NUM_DOMAINS'(1);
  assign state          = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RESET_PLL;
      cnt           <= '0;
      pll_rst       <= 1'b1;
      domain_rst_n  <= '0;
      ready         <= 1'b0;
      lock_lost_cnt <= 8'd0;
      timeout_err   <= 1'b0;
    end else if (sw_reset_req) begin
      state_q      <= RESET_PLL;
      cnt          <= '0;
      pll_rst      <= 1'b1;
      domain_rst_n <= '0;
      ready        <= 1'b0;
    end else begin
      case (state_q)
        RESET_PLL: begin
          if (cnt == HOLD_LAST) begin
            state_q <= WAIT_LOCK;
            cnt     <= '0;
            pll_rst <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        WAIT_LOCK: begin
          if (lock_s) begin
            state_q <= STABLE;
            cnt     <= '0;
          end else if (cnt == TIMEOUT_LAST) begin
            timeout_err <= 1'b1;
            cnt         <= '0;
            pll_rst     <= 1'b1;
`ifdef PLL_RETRY_EN
            state_q     <= RESET_PLL;
`else
            state_q     <= FAULT;
`endif
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        // A dropout here is a normal part of acquisition, not a counted loss.
        STABLE: begin
          if (!lock_s) begin
            state_q <= WAIT_LOCK;
            cnt     <= '0;
          end else if (cnt == STABLE_LAST) begin
            state_q <= RELEASE;
            cnt     <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        RELEASE: begin
          if (!lock_s) begin
            state_q      <= RESET_PLL;
            cnt          <= '0;
            pll_rst      <= 1'b1;
            domain_rst_n <= '0;
            ready        <= 1'b0;
            if (lock_lost_cnt != 8'hFF) lock_lost_cnt <= lock_lost_cnt + 8'd1;
          end else if (cnt == GAP_LAST) begin
            cnt          <= '0;
            domain_rst_n <= release_mask_c;
            if (&release_mask_c) begin
              state_q <= RUN;
              ready   <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        RUN: begin
          if (!lock_s) begin
            state_q      <= RESET_PLL;
            cnt          <= '0;
            pll_rst      <= 1'b1;
            domain_rst_n <= '0;
            ready        <= 1'b0;
            if (lock_lost_cnt != 8'hFF) lock_lost_cnt <= lock_lost_cnt + 8'd1;
          end
        end

        FAULT: begin
          pll_rst      <= 1'b1;
          domain_rst_n <= '0;
          ready        <= 1'b0;
        end

        default: begin
          state_q      <= RESET_PLL;
          cnt          <= '0;
          pll_rst      <= 1'b1;
          domain_rst_n <= '0;
          ready        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reset_seq.sv
// Self-checking bench for pll_reset_seq: phase/elapsed-time model plus directed checks.
module tb_pll_reset_seq;
  import pll_seq_pkg::*;

  localparam int HOLD = 4;
  localparam int STAB = 8;
  localparam int TMO  = 32;
  localparam int GAP  = 2;
  localparam int ND   = 4;

  // Model phases
  localparam int P_HOLD  = 10;
  localparam int P_WAIT  = 11;
  localparam int P_STAB  = 12;
  localparam int P_REL   = 13;
  localparam int P_RUN   = 14;
  localparam int P_FAULT = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sw_reset_req = 1'b0;
  logic          pll_locked = 1'b0;
  logic          pll_rst;
  logic [ND-1:0] domain_rst_n;
  logic          ready;
  logic [7:0]    lock_lost_cnt;
  logic          timeout_err;
  logic [2:0]    state;

  int n_checks = 0;
  int n_fail   = 0;

  int m_phase = P_HOLD;
  int m_t     = 0;
  int m_lost  = 0;
  bit m_terr  = 1'b0;
  bit m_s1    = 1'b0;
  bit m_s2    = 1'b0;

  pll_reset_seq #(
    .RST_HOLD_CYCLES    (HOLD),
    .LOCK_STABLE_CYCLES (STAB),
    .LOCK_TIMEOUT_CYCLES(TMO),
    .RELEASE_GAP        (GAP),
    .NUM_DOMAINS        (ND)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sw_reset_req (sw_reset_req),
    .pll_locked   (pll_locked),
    .pll_rst      (pll_rst),
    .domain_rst_n (domain_rst_n),
    .ready        (ready),
    .lock_lost_cnt(lock_lost_cnt),
    .timeout_err  (timeout_err),
    .state        (state)
  );

  always #5 clk = ~clk;

  function automatic logic [ND-1:0] exp_dom(input int ph, input int t);
    if (ph == P_RUN) return {ND{1'b1}};
    if (ph == P_REL) return ND'((1 << (t / GAP)) - 1);
    return '0;
  endfunction

  function automatic logic [2:0] exp_state(input int ph);
    case (ph)
      P_WAIT:  return 3'(WAIT_LOCK);
      P_STAB:  return 3'(STABLE);
      P_REL:   return 3'(RELEASE);
      P_RUN:   return 3'(RUN);
      P_FAULT: return 3'(FAULT);
      default: return 3'(RESET_PLL);
    endcase
  endfunction

  // Model: phase plus cycles elapsed in it; lock seen two edges late.
  initial forever begin
    bit ls;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_phase = P_HOLD; m_t = 0; m_lost = 0; m_terr = 1'b0; m_s1 = 1'b0; m_s2 = 1'b0;
    end else begin
      ls = m_s2;
      m_s2 = m_s1;
      m_s1 = pll_locked;
      m_t = m_t + 1;
      if (sw_reset_req) begin
        m_phase = P_HOLD; m_t = 0;
      end else if ((m_phase == P_REL || m_phase == P_RUN) && !ls) begin
        m_lost = (m_lost >= 255) ? 255 : m_lost + 1;
        m_phase = P_HOLD; m_t = 0;
      end else if (m_phase == P_HOLD && m_t == HOLD) begin
        m_phase = P_WAIT; m_t = 0;
      end else if (m_phase == P_WAIT && ls) begin
        m_phase = P_STAB; m_t = 0;
      end else if (m_phase == P_WAIT && m_t == TMO) begin
        m_terr = 1'b1;
`ifdef PLL_RETRY_EN
        m_phase = P_HOLD;
`else
        m_phase = P_FAULT;
`endif
        m_t = 0;
      end else if (m_phase == P_STAB && !ls) begin
        m_phase = P_WAIT; m_t = 0;
      end else if (m_phase == P_STAB && m_t == STAB) begin
        m_phase = P_REL; m_t = 0;
      end else if (m_phase == P_REL && m_t == ND * GAP) begin
        m_phase = P_RUN; m_t = 0;
      end
    end
  end

  // Every-cycle comparison against the model, mid-cycle.
  initial forever begin
    logic [ND-1:0] ed;
    logic [2:0]    es;
    logic          ep, er;
    @(negedge clk);
    ed = exp_dom(m_phase, m_t);
    es = exp_state(m_phase);
    ep = (m_phase == P_HOLD || m_phase == P_FAULT);
    er = (m_phase == P_RUN);
    n_checks++;
    if (pll_rst !== ep || domain_rst_n !== ed || ready !== er ||
        lock_lost_cnt !== 8'(m_lost) || timeout_err !== m_terr || state !== es) begin
      n_fail++;
      $display("FAIL model_cycle t=%0t got rst=%b dom=%h rdy=%b lost=%0d terr=%b st=%0d exp rst=%b dom=%h rdy=%b lost=%0d terr=%b st=%0d",
               $time, pll_rst, domain_rst_n, ready, lock_lost_cnt, timeout_err, state,
               ep, ed, er, m_lost, m_terr, es);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_phase(input int p, input int budget);
    int n;
    n = 0;
    while (m_phase != p && n < budget) begin
      tick(1);
      n++;
    end
    n_checks++;
    if (m_phase != p) begin
      n_fail++;
      $display("FAIL wait_phase: got phase %0d expected %0d within %0d cycles", m_phase, p, budget);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    rst_n = 1'b1;                          // edge 0 reference
    check("reset_pll_rst", 32'(pll_rst), 32'd1);
    check("reset_dom", 32'(domain_rst_n), 32'h0);
    check("reset_ready", 32'(ready), 32'd0);
    check("reset_lost", 32'(lock_lost_cnt), 32'd0);
    check("reset_terr", 32'(timeout_err), 32'd0);
    check("reset_state", 32'(state), 32'(RESET_PLL));

    // Nominal bring-up
    tick(3);  check("hold_edge3", 32'(pll_rst), 32'd1);
    tick(1);  check("hold_edge4", 32'(pll_rst), 32'd0);
    tick(6);  pll_locked = 1'b1;           // edge 10
    tick(12); check("rel_e22", 32'(domain_rst_n), 32'h0);
    tick(1);  check("rel_e23", 32'(domain_rst_n), 32'h1);
    tick(2);  check("rel_e25", 32'(domain_rst_n), 32'h3);
    tick(2);  check("rel_e27", 32'(domain_rst_n), 32'h7);
              check("rdy_e27", 32'(ready), 32'd0);
    tick(2);  check("rel_e29", 32'(domain_rst_n), 32'hF);
              check("rdy_e29", 32'(ready), 32'd1);

    // Software restart from RUN, then lock glitch while STABLE
    sw_reset_req = 1'b1;
    tick(1);  sw_reset_req = 1'b0;         // k+1
    check("sw_state", 32'(state), 32'(RESET_PLL));
    check("sw_dom", 32'(domain_rst_n), 32'h0);
    tick(8);  check("stab_state", 32'(state), 32'(STABLE));
    pll_locked = 1'b0;
    tick(3);  pll_locked = 1'b1;           // k+12
    check("glitch_state", 32'(state), 32'(WAIT_LOCK));
    check("glitch_lost", 32'(lock_lost_cnt), 32'd0);
    tick(12); check("glitch_norel", 32'(domain_rst_n), 32'h0);
    tick(1);  check("glitch_rel0", 32'(domain_rst_n), 32'h1);
    tick(6);  check("glitch_run", 32'(ready), 32'd1);

    // Lock loss in RUN, held low into a timeout
    pll_locked = 1'b0;                     // j
    tick(2);  check("loss_j2_dom", 32'(domain_rst_n), 32'hF);
    tick(1);  check("loss_j3_dom", 32'(domain_rst_n), 32'h0);
              check("loss_j3_rdy", 32'(ready), 32'd0);
              check("loss_j3_lost", 32'(lock_lost_cnt), 32'd1);
              check("loss_j3_prst", 32'(pll_rst), 32'd1);
    tick(35); check("tmo_before", 32'(timeout_err), 32'd0);
              check("tmo_before_st", 32'(state), 32'(WAIT_LOCK));
    tick(1);  check("tmo_flag", 32'(timeout_err), 32'd1);
              check("tmo_prst", 32'(pll_rst), 32'd1);
`ifdef PLL_RETRY_EN
    check("tmo_retry_state", 32'(state), 32'(RESET_PLL));
    tick(5);  check("retry_wait", 32'(state), 32'(WAIT_LOCK));
`else
    check("tmo_fault_state", 32'(state), 32'(FAULT));
    tick(5);  check("fault_held", 32'(state), 32'(FAULT));
`endif
    sw_reset_req = 1'b1;
    tick(1);  sw_reset_req = 1'b0;
    check("sw_exit_state", 32'(state), 32'(RESET_PLL));
    check("terr_sticky", 32'(timeout_err), 32'd1);

    // sw_reset_req coincident with lock loss in RUN
    pll_locked = 1'b1;
    wait_phase(P_RUN, 100);
    pll_locked = 1'b0;
    tick(2);  sw_reset_req = 1'b1;
    tick(1);  sw_reset_req = 1'b0;
    check("coinc_state", 32'(state), 32'(RESET_PLL));
    check("coinc_lost", 32'(lock_lost_cnt), 32'd1);
    check("coinc_dom", 32'(domain_rst_n), 32'h0);
    pll_locked = 1'b1;

    // Saturation of the loss counter
    for (int i = 0; i < 260; i++) begin
      wait_phase(P_REL, 64);
      pll_locked = 1'b0;
      tick(1);
      pll_locked = 1'b1;
      tick(3);
      if (i == 0) check("sat_first", 32'(lock_lost_cnt), 32'd2);
    end
    check("sat_final", 32'(lock_lost_cnt), 32'd255);
    tick(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
